vga_pixel_feeder: RTL and testbench
===================================

// Module: vga_pixel_feeder
// PURPOSE
//  Upstream feeder for the VGA controller. Buffers the grayscale stream from
//  the Sobel/pixel pipeline in a small FIFO and pops one pixel per active-video
//  request (iRequest). Aligns the pixel stream to the VGA frame using a
//  start-of-frame flag. Drives iRed/iGreen/iBlue with a 10-bit gray expansion.
// PARAMETERS
//  DATA_W      8    input pixel width; legal range 5..10
//  FIFO_DEPTH  16   FIFO entries; power of 2, >=4
//  H_ACT       640  active pixels per line
//  V_ACT       480  active lines per frame
// PORTS
//  iCLK           in   1       pixel clock; same clock as the VGA controller
//  iRST_N         in   1       asynchronous reset, active-low
//  iPix_data      in   DATA_W  grayscale pixel
//  iPix_sof       in   1       marks the first pixel of a frame (X=0,Y=0)
//  iPix_valid     in   1       iPix_data/iPix_sof are valid
//  oPix_ready     out  1       FIFO can accept data; push = valid & ready
//  iRequest       in   1       VGA active-video pixel request
//  iCurrent_X     in   11      VGA pixel X (0 outside active)
//  iCurrent_Y     in   11      VGA pixel Y (0 outside active)
//  iClear_err     in   1       clears oUnderflow and oResync (sticky flags)
//  oRed/oGreen/oBlue out 10    gray pixel to the VGA controller (all equal)
//  oFrame_locked  out  1       high while in STREAM state
//  oUnderflow     out  1       sticky: a request arrived while in STREAM with FIFO empty
//  oResync        out  1       sticky: an sof arrived early or a frame was missing
// BEHAVIOUR
//  Reset: FIFO empty, state SEEK, pixel counter 0, oRed/G/B=0, flags 0,
//   oFrame_locked=0. oPix_ready = !full, so it is 1 while in reset and after reset.
//  Pop occurs only when the FIFO count is nonzero (registered); there is no
//   push-to-pop bypass. Push and pop in the same cycle leave the count unchanged.
//  States:
//   SEEK: pop and discard the head every cycle while head.sof==0.
//    Go to WAIT when head.sof==1. Do not pop in that cycle.
//   WAIT: hold the sof pixel at the head. On iRequest with X==0 and Y==0,
//    pop it, output it, counter<=1, go to STREAM.
//   STREAM: on each iRequest pop one pixel and counter++.
//    If the FIFO is empty, output 0, set oUnderflow, and still counter++.
//    If head.sof==1 when counter!=0, do not pop, set oResync, go to WAIT.
//    When counter reaches H_ACT*V_ACT, counter<=0 and go to WAIT.
//    If the head is not sof at that point, go to SEEK and set oResync.
//  Output: registered; oRed/G/B update one cycle after the iRequest that
//   popped. The top level offsets the controller timing by 1 pixel.
//   With no request, outputs are 0.
//  Gray expansion: out10 = {p, p[DATA_W-1 -: 10-DATA_W]}, i.e. MSBs are
//   replicated into the LSBs. DATA_W==10 passes p through unchanged.
//   0x00 maps to 10'h000; 0xFF maps to 10'h3FF.
//  Counter: $clog2(H_ACT*V_ACT+1) bits, no wrap beyond the frame size.
//  iClear_err has priority over a same-cycle flag set (clear wins).
//  Reset mid-frame: everything returns to the reset state and FIFO contents
//   are discarded.
// STRUCTURE
//  Shared include vga_params.vh: H_ACT/V_ACT defaults and the state encodings
//   S_SEEK=2'd0, S_WAIT=2'd1, S_STREAM=2'd2.
//  Sub-module pix_fifo: synchronous FIFO, width DATA_W+1 ({sof,data}),
//   show-ahead head, outputs full/empty, async active-low reset.
//  Top level: the FSM, the pixel counter, sticky flags, and the expansion register.
// TESTING
//  Use H_ACT=4, V_ACT=2 for speed.
//  1 Reset, then push 8 pixels (sof on the first) and issue requests at X,Y=0..3,0..1
//    -> 8 outputs in order, each 1 cycle after its request, oFrame_locked high,
//    then WAIT state.
//  2 Push 3 non-sof pixels, then sof -> the 3 pixels are dropped in SEEK and no
//    output is produced until the X=0,Y=0 request.
//  3 Starve the FIFO after 5 pixels -> requests 6..8 output 0 and oUnderflow=1.
//    iClear_err -> 0.
//  4 Inject sof as the 3rd pixel of a frame -> oResync=1, no pop, WAIT state,
//    and a re-lock on the next X=0,Y=0 request.
//  5 DATA_W=8: pixels 0x00, 0x80, 0xFF -> outputs 10'h000, 10'h202, 10'h3FF.
//  6 Hold iPix_valid=1 with no requests -> oPix_ready=0 after 16 pushes and no
//    overwrite. Assert iRST_N low mid-STREAM -> all outputs 0 and oPix_ready=1.

Source files
------------

// File: rtl/vga_pixel_feeder_pkg.sv
// Shared definitions for the VGA pixel feeder: default active-video geometry
// and the frame-alignment state encoding.
package vga_pixel_feeder_pkg;

   localparam int H_ACT_DEF = 640;
   localparam int V_ACT_DEF = 480;

   typedef enum logic [1:0] {
      S_SEEK   = 2'd0,
      S_WAIT   = 2'd1,
      S_STREAM = 2'd2
   } feedState_t;

endpackage

// File: rtl/vga_pixel_feeder_pix_fifo.sv
// Synchronous show-ahead FIFO holding {sof,data} entries for the pixel feeder.
// Head is valid whenever oEmpty is low; push when full and pop when empty are ignored.
module pix_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iPush,
   input  logic [WIDTH-1:0] iData,
   input  logic             iPop,
   output logic [WIDTH-1:0] oHead,
   output logic             oFull,
   output logic             oEmpty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr, rdPtr;
   logic [AW:0]      count;
   logic             doPush, doPop;

   assign oFull  = (count == FULL_CNT);
   assign oEmpty = (count == '0);
   assign doPush = iPush & ~oFull;
   assign doPop  = iPop & ~oEmpty;
   assign oHead  = mem[rdPtr];

   // storage needs no reset: the count alone defines which entries are live
   always_ff @(posedge iCLK) begin
      if (doPush) mem[wrPtr] <= iData;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Buffers the grayscale pixel stream, aligns it to the VGA raster on sof and
// serves one 10-bit gray pixel per active-video request, one cycle later.
module vga_pixel_feeder
   import vga_pixel_feeder_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int H_ACT      = H_ACT_DEF,
   parameter int V_ACT      = V_ACT_DEF
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [DATA_W-1:0] iPix_data,
   input  logic              iPix_sof,
   input  logic              iPix_valid,
   output logic              oPix_ready,
   input  logic              iRequest,
   input  logic [10:0]       iCurrent_X,
   input  logic [10:0]       iCurrent_Y,
   input  logic              iClear_err,
   output logic [9:0]        oRed,
   output logic [9:0]        oGreen,
   output logic [9:0]        oBlue,
   output logic              oFrame_locked,
   output logic              oUnderflow,
   output logic              oResync
);

   localparam int FRAME = H_ACT * V_ACT;
   localparam int CNT_W = $clog2(FRAME + 1);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);

   feedState_t        state, nextState;
   logic [CNT_W-1:0]  cnt, nextCnt;
   logic [DATA_W:0]   head;
   logic              fifoFull, fifoEmpty;
   logic              pop, loadPix, setUnder, setResync;
   logic              headSof, atOrigin;
   logic [DATA_W-1:0] headPix;
   logic [9:0]        grayExp, pixOut;

   pix_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) uFifo (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iPush  (iPix_valid),
      .iData  ({iPix_sof, iPix_data}),
      .iPop   (pop),
      .oHead  (head),
      .oFull  (fifoFull),
      .oEmpty (fifoEmpty)
   );

   assign oPix_ready = ~fifoFull;
   assign headSof    = head[DATA_W];
   assign headPix    = head[DATA_W-1:0];
   assign atOrigin   = (iCurrent_X == '0) && (iCurrent_Y == '0);

   // replicate the MSBs into the vacated LSBs so full scale maps to 10'h3FF
   generate
      if (DATA_W == 10) begin : gFull
         assign grayExp = headPix;
      end else begin : gExpand
         assign grayExp = {headPix, headPix[DATA_W-1 -: 10-DATA_W]};
      end
   endgenerate

   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      pop       = 1'b0;
      loadPix   = 1'b0;
      setUnder  = 1'b0;
      setResync = 1'b0;
      case (state)
         S_SEEK: begin
            if (!fifoEmpty) begin
               if (headSof) nextState = S_WAIT;
               else         pop = 1'b1;
            end
         end
         S_WAIT: begin
            // a non-sof head here means the next frame started without its marker
            if (!fifoEmpty) begin
               if (!headSof) begin
                  nextState = S_SEEK;
               end else if (iRequest && atOrigin) begin
                  pop       = 1'b1;
                  loadPix   = 1'b1;
                  nextCnt   = CNT_W'(1);
                  nextState = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (cnt == FRAME_CNT) begin
               nextCnt = '0;
               if (!fifoEmpty && !headSof) begin
                  nextState = S_SEEK;
                  setResync = 1'b1;
               end else begin
                  nextState = S_WAIT;
               end
            end else if (iRequest) begin
               if (fifoEmpty) begin
                  setUnder = 1'b1;
                  nextCnt  = cnt + 1'b1;
               end else if (headSof) begin
                  setResync = 1'b1;
                  nextState = S_WAIT;
               end else begin
                  pop     = 1'b1;
                  loadPix = 1'b1;
                  nextCnt = cnt + 1'b1;
               end
            end
         end
         default: nextState = S_SEEK;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= S_SEEK;
         cnt        <= '0;
         pixOut     <= '0;
         oUnderflow <= 1'b0;
         oResync    <= 1'b0;
      end else begin
         state  <= nextState;
         cnt    <= nextCnt;
         pixOut <= loadPix ? grayExp : 10'd0;
         if (iClear_err)    oUnderflow <= 1'b0;
         else if (setUnder) oUnderflow <= 1'b1;
         if (iClear_err)     oResync <= 1'b0;
         else if (setResync) oResync <= 1'b1;
      end
   end

   assign oRed          = pixOut;
   assign oGreen        = pixOut;
   assign oBlue         = pixOut;
   assign oFrame_locked = (state == S_STREAM);

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Scoreboard bench for vga_pixel_feeder on a 4x2 raster: a queue-based frame model
// predicts each request's pixel; a monitor compares the RGB outputs every cycle.
module tb_vga_pixel_feeder;

   localparam int DW = 8, DEPTH = 16, HA = 4, VA = 2, FRAME = HA * VA;
   localparam int M_SEEK = 0, M_WAIT = 1, M_STREAM = 2;

   logic          iCLK = 1'b0, iRST_N = 1'b0;
   logic [DW-1:0] iPix_data = '0;
   logic          iPix_sof = 1'b0, iPix_valid = 1'b0, oPix_ready;
   logic          iRequest = 1'b0, iClear_err = 1'b0;
   logic [10:0]   iCurrent_X = '0, iCurrent_Y = '0;
   logic [9:0]    oRed, oGreen, oBlue;
   logic          oFrame_locked, oUnderflow, oResync;

   vga_pixel_feeder #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .H_ACT(HA), .V_ACT(VA)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iPix_data(iPix_data), .iPix_sof(iPix_sof),
      .iPix_valid(iPix_valid), .oPix_ready(oPix_ready), .iRequest(iRequest),
      .iCurrent_X(iCurrent_X), .iCurrent_Y(iCurrent_Y), .iClear_err(iClear_err),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oFrame_locked(oFrame_locked),
      .oUnderflow(oUnderflow), .oResync(oResync)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0, errors = 0;

   // reference model: queued pixels, alignment mode, raster position, sticky flags
   logic [8:0] mq[$];
   int         mMode = M_SEEK, mPos = 0;
   bit         mUnder = 0, mResync = 0;
   logic [9:0] expq[$];
   bit         reqSeen = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] gray(input logic [7:0] p);
      int v;
      v = int'(p) * 4 + int'(p) / 64;
      return v[9:0];
   endfunction

   // bring the model to where the hardware settles after idle cycles
   function automatic void settle();
      bit again = 1;
      while (again) begin
         again = 0;
         if (mMode == M_SEEK) begin
            while (mq.size() > 0 && !mq[0][8]) void'(mq.pop_front());
            if (mq.size() > 0) mMode = M_WAIT;
         end
         if (mMode == M_WAIT && mq.size() > 0 && !mq[0][8]) begin
            mMode = M_SEEK;
            again = 1;
         end
      end
   endfunction

   task automatic model_req(input int x, input int y, output logic [9:0] e, output bit done);
      logic [8:0] h;
      e = '0;
      done = 0;
      settle();
      if (mMode == M_WAIT) begin
         if (x == 0 && y == 0 && mq.size() > 0) begin
            h = mq.pop_front();
            e = gray(h[7:0]);
            mPos = 1;
            mMode = M_STREAM;
         end
      end else if (mMode == M_STREAM) begin
         if (mq.size() == 0) begin
            mUnder = 1;
            mPos++;
         end else if (mq[0][8]) begin
            mResync = 1;
            mMode = M_WAIT;
         end else begin
            h = mq.pop_front();
            e = gray(h[7:0]);
            mPos++;
         end
         if (mMode == M_STREAM && mPos == FRAME) begin
            done = 1;
            mPos = 0;
            if (mq.size() > 0 && !mq[0][8]) begin
               mMode = M_SEEK;
               mResync = 1;
            end else begin
               mMode = M_WAIT;
            end
         end
      end
   endtask

   always @(posedge iCLK) reqSeen <= iRequest;

   always @(negedge iCLK) begin
      logic [9:0] e;
      e = '0;
      if (reqSeen) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underrun actual=empty required=entry at %0t", $time);
         end else begin
            e = expq.pop_front();
         end
      end
      chk("pix_red", oRed, e);
      chk("pix_green", oGreen, e);
      chk("pix_blue", oBlue, e);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic push_px(input bit sof, input logic [7:0] d);
      iPix_valid = 1'b1;
      iPix_sof   = sof;
      iPix_data  = d;
      chk("ready_push", oPix_ready, 1);
      mq.push_back({sof, d});
      @(negedge iCLK);
      iPix_valid = 1'b0;
      iPix_sof   = 1'b0;
   endtask

   task automatic push_frame(input int n);
      push_px(1'b1, 8'($urandom));
      for (int i = 1; i < n; i++) push_px(1'b0, 8'($urandom));
   endtask

   task automatic req(input int x, input int y, input bit clr = 0);
      logic [9:0] e;
      bit done;
      iRequest   = 1'b1;
      iCurrent_X = 11'(x);
      iCurrent_Y = 11'(y);
      iClear_err = clr;
      model_req(x, y, e, done);
      if (clr) begin
         mUnder = 0;
         mResync = 0;
      end
      expq.push_back(e);
      @(negedge iCLK);
      iRequest   = 1'b0;
      iCurrent_X = '0;
      iCurrent_Y = '0;
      iClear_err = 1'b0;
      @(negedge iCLK);
      if (done) idle(20);
   endtask

   task automatic raster(input int s, input int n);
      for (int i = 0; i < n; i++) req(((s + i) % FRAME) % HA, ((s + i) % FRAME) / HA);
   endtask

   task automatic clear_pulse();
      iClear_err = 1'b1;
      mUnder = 0;
      mResync = 0;
      @(negedge iCLK);
      iClear_err = 1'b0;
   endtask

   task automatic stat(input string nm);
      settle();
      chk({nm, "_locked"}, oFrame_locked, int'(mMode == M_STREAM));
      chk({nm, "_underflow"}, oUnderflow, mUnder);
      chk({nm, "_resync"}, oResync, mResync);
   endtask

   task automatic model_reset();
      mq.delete();
      mMode = M_SEEK;
      mPos = 0;
      mUnder = 0;
      mResync = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle(3);
      chk("reset_ready", oPix_ready, 1);
      stat("reset");
      iRST_N = 1'b1;
      idle(2);

      // 1: one aligned frame
      push_frame(8);
      idle(20);
      stat("t1_pre");
      raster(0, 4);
      stat("t1_mid");
      raster(4, 4);
      stat("t1_end");

      // 2: leading non-sof pixels are dropped
      for (int i = 0; i < 3; i++) push_px(1'b0, 8'($urandom));
      push_frame(8);
      idle(20);
      req(1, 0);
      req(2, 1);
      raster(0, 8);
      stat("t2");

      // 3: starvation, clear beats a same-cycle set
      push_frame(5);
      idle(20);
      raster(0, 6);
      stat("t3_starve");
      req(2, 1, 1'b1);
      req(3, 1);
      stat("t3_end");
      clear_pulse();
      stat("t3_clr");

      // 4: early sof then re-lock
      push_px(1'b1, 8'($urandom));
      push_px(1'b0, 8'($urandom));
      push_frame(8);
      idle(20);
      raster(0, 4);
      stat("t4_early");
      raster(0, 8);
      stat("t4_relock");
      clear_pulse();

      // 5: expansion end points
      push_px(1'b1, 8'h00);
      push_px(1'b0, 8'h80);
      push_px(1'b0, 8'hFF);
      for (int i = 0; i < 5; i++) push_px(1'b0, 8'($urandom));
      idle(20);
      raster(0, 8);
      stat("t5");

      // 6: fill to full, no overwrite, then async reset mid-stream
      iRST_N = 1'b0;
      model_reset();
      idle(2);
      iRST_N = 1'b1;
      push_frame(8);
      push_frame(8);
      iPix_valid = 1'b1;
      iPix_data  = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         chk("ready_full", oPix_ready, 0);
         @(negedge iCLK);
      end
      iPix_valid = 1'b0;
      idle(20);
      raster(0, 8);
      raster(0, 2);
      stat("t6_stream");
      #2 iRST_N = 1'b0;
      model_reset();
      #1;
      chk("t6_async_locked", oFrame_locked, 0);
      chk("t6_async_ready", oPix_ready, 1);
      idle(2);
      stat("t6_reset");
      iRST_N = 1'b1;
      idle(2);

      // random traffic
      for (int it = 0; it < 40; it++) begin
         int n;
         settle();
         n = $urandom_range(0, DEPTH - mq.size());
         for (int i = 0; i < n; i++) push_px($urandom_range(0, 4) == 0, 8'($urandom));
         idle(20);
         if ($urandom_range(0, 3) == 0) clear_pulse();
         raster($urandom_range(0, 1) ? 0 : $urandom_range(0, FRAME - 1), $urandom_range(1, 10));
         idle(20);
         stat("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
